// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential 32-bit binary to 8-digit packed BCD converter.
// Uses shift-add-3 (double dabble), one bit per clock, with a start/busy/done
// handshake. The result registers hold between conversions, so the downstream
// display never sees intermediate values.
// Optional build macro: BCD_SATURATE_EN. When defined, an out-of-range result
// (value > 99,999,999) is shown as 32'h99999999. Otherwise the low 8 digits
// are shown. The overflow flag is set in both builds.
//
// Handshake: start is sampled only in IDLE, and bin_in is captured on that same
// edge. busy is high from the accepting edge until the publishing edge. done is
// a one-cycle pulse that appears together with the updated bcd_out/overflow.
// A start seen while busy is dropped, not queued.
module bin_to_bcd_seq (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] bcd_out,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] shift_reg;
    // Ten digits wide, so overflow detection is exact for any 32-bit input.
    logic [39:0] scratch;
    logic [5:0]  cnt;
    logic [39:0] adj;
    logic        ovf_det;

    // Add 3 to every scratch digit that is 5 or more. Each digit is a
    // 4-bit add; no carry passes between digits.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < 10; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    assign ovf_det = |scratch[39:32];

    // Conversion FSM: accept, shift 32 bits, then publish for one cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            shift_reg <= 32'h0;
            scratch   <= 40'h0;
            cnt       <= 6'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= 32'h0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shift_reg <= bin_in;
                        scratch   <= 40'h0;
                        cnt       <= 6'd0;
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // The adjusted scratch shifts left, and the next input bit
                    // (the shift register MSB) enters at the scratch LSB.
                    scratch   <= {adj[38:0], shift_reg[31]};
                    shift_reg <= {shift_reg[30:0], 1'b0};
                    cnt       <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= DONE;
                    end
                end
                DONE: begin
`ifdef BCD_SATURATE_EN
                    bcd_out <= ovf_det ? 32'h99999999 : scratch[31:0];
`else
                    bcd_out <= scratch[31:0];
`endif
                    overflow <= ovf_det;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Testbench for bin_to_bcd_seq: directed vectors with hand-computed BCD results.
// Inputs are driven and outputs are sampled 1ns after each rising edge.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    bin_to_bcd_seq dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    // 10ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start  = 1'b1;   // reset must win over start
        bin_in = 32'd5;
        step();
        step();
        start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (bcd_out !== 32'h0) begin n_fail++; $display("FAIL reset_bcd: got %h expected 00000000", bcd_out); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        resetn = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    // Full conversion: checks latency, busy length, the done pulse width and the result.
    task automatic convert(input logic [31:0] value, input logic [31:0] exp_bcd,
                           input logic exp_ovf, input string name);
        int lat;
        int busy_cnt;
        start  = 1'b1;
        bin_in = value;
        step();              // accepting edge k
        start  = 1'b0;
        bin_in = 32'hDEADBEEF;
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL %s_latency: got %0d expected 33", name, lat); end
        n_checks++; if (busy_cnt !== 33) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d expected 33", name, busy_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_at_done: got %b expected 0", name, busy); end
        n_checks++; if (bcd_out !== exp_bcd) begin n_fail++; $display("FAIL %s_bcd: got %h expected %h", name, bcd_out, exp_bcd); end
        n_checks++; if (overflow !== exp_ovf) begin n_fail++; $display("FAIL %s_ovf: got %b expected %b", name, overflow, exp_ovf); end
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_width: got %b expected 0", name, done); end
        n_checks++; if (bcd_out !== exp_bcd) begin n_fail++; $display("FAIL %s_bcd_hold: got %h expected %h", name, bcd_out, exp_bcd); end
    endtask

    task automatic test_zero();
        convert(32'd0, 32'h00000000, 1'b0, "zero");
    endtask

    task automatic test_values();
        convert(32'h00BC614E, 32'h12345678, 1'b0, "v12345678");
        convert(32'h05F5E0FF, 32'h99999999, 1'b0, "v99999999");
`ifdef BCD_SATURATE_EN
        convert(32'h05F5E100, 32'h99999999, 1'b1, "v100000000");
        convert(32'hFFFFFFFF, 32'h99999999, 1'b1, "vmax");
`else
        convert(32'h05F5E100, 32'h00000000, 1'b1, "v100000000");
        convert(32'hFFFFFFFF, 32'h94967295, 1'b1, "vmax");
`endif
    endtask

    // Starts at k+5 and k+33 are ignored. bin_in changes mid-run have no effect. A start at k+34 is accepted.
    task automatic test_back_to_back();
        int done_cnt;
        int done_at;
        logic [31:0] prev;
        prev   = bcd_out;
        start  = 1'b1;
        bin_in = 32'd42;
        step();               // edge k
        start  = 1'b0;
        done_cnt = 0;
        done_at  = 0;
        for (int i = 1; i <= 40; i++) begin
            step();           // sampled after edge k+i
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            if (i == 20) begin
                n_checks++; if (bcd_out !== prev) begin n_fail++; $display("FAIL b2b_hold_mid: got %h expected %h", bcd_out, prev); end
            end
            if (i == 33) begin
                n_checks++; if (bcd_out !== 32'h00000042) begin n_fail++; $display("FAIL b2b_bcd42: got %h expected 00000042", bcd_out); end
            end
            if (i == 34) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_k34: got %b expected 1", busy); end
                n_checks++; if (bcd_out !== 32'h00000042) begin n_fail++; $display("FAIL b2b_hold_after_accept: got %h expected 00000042", bcd_out); end
            end
            // Drive the next edge's inputs.
            start = 1'b0;
            if (i == 4)  begin start = 1'b1; bin_in = 32'd7; end     // sampled at k+5
            if (i == 15) bin_in = 32'd99;                            // change mid-run
            if (i == 32 || i == 33) begin start = 1'b1; bin_in = 32'd7; end  // k+33 ignored, k+34 accepted
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", done_cnt); end
        n_checks++; if (done_at !== 33) begin n_fail++; $display("FAIL b2b_done_at: got %0d expected 33", done_at); end
        // The conversion accepted at k+34 finishes at k+67.
        done_at = 0;
        for (int i = 41; i <= 75; i++) begin
            step();
            if (done) begin
                done_at = i;
                break;
            end
        end
        n_checks++; if (done_at !== 67) begin n_fail++; $display("FAIL b2b_second_done_at: got %0d expected 67", done_at); end
        n_checks++; if (bcd_out !== 32'h00000007) begin n_fail++; $display("FAIL b2b_second_bcd: got %h expected 00000007", bcd_out); end
        step();
    endtask

    // Reset during a conversion aborts it, clears the outputs and produces no done pulse.
    task automatic test_reset_mid();
        int done_cnt;
        convert(32'd1234, 32'h00001234, 1'b0, "v1234");
        start  = 1'b1;
        bin_in = 32'd5678;
        step();               // edge k
        start  = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i == 9) resetn = 1'b0;    // sampled at edge k+10
        end
        step();
        resetn = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", done); end
        n_checks++; if (bcd_out !== 32'h0) begin n_fail++; $display("FAIL rstmid_bcd: got %h expected 00000000", bcd_out); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_ovf: got %b expected 0", overflow); end
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done) done_cnt++;
        end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt); end
        convert(32'd5678, 32'h00005678, 1'b0, "v5678_after_reset");
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        bin_in = 32'h0;
        test_reset();
        test_zero();
        test_values();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using iterative shift-add-3 (double dabble), one bit per clock. It sits directly upstream of the 8-digit seven-segment hex display driver: its 32-bit packed BCD output drives the display's `num_in`, so a binary register value shows as decimal digits. It uses a start/busy/done handshake. The output register holds its value between conversions, so the display never shows intermediate values.

## Interface
- No parameters; widths fixed: 32-bit binary in, 8 BCD digits out.
- `clk`  in  1  clock; all state updates on rising edge.
- `resetn`  in  1  reset, synchronous, active-low.
- `start`  in  1  request conversion of `bin_in`; sampled only in IDLE.
- `bin_in`  in  32  unsigned binary value; sampled on the accepting edge only.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  single-cycle pulse; `bcd_out` and `overflow` are updated in the same cycle.
- `bcd_out`  out  32  packed BCD; digit i is in bits [4i+3:4i], with digit 0 least significant.
- `overflow`  out  1  last converted value was greater than 99,999,999.

## Operation
- Registered state machine with three states:
  - IDLE: waiting for a request.
  - SHIFT: 32 iterations.
  - DONE: one cycle to publish results.
- IDLE with `start`=1:
  - load the 32-bit shift register from `bin_in`;
  - clear the 40-bit scratch (10 BCD digits) and the 6-bit iteration counter;
  - set `busy`=1 and go to SHIFT.
- SHIFT, each cycle:
  - every scratch digit ≥5 gets +3 (4-bit add, no carry between digits);
  - then {scratch, shift} shifts left 1, so scratch LSB takes the shift MSB;
  - counter increments. After the 32nd iteration (counter == 31 at the edge), go to DONE.
- DONE:
  - `bcd_out` ← scratch[31:0] (subject to Configuration);
  - `overflow` ← |scratch[39:32];
  - `done`=1 for one cycle, `busy`=0, return to IDLE.
- `start` while not in IDLE (SHIFT or DONE) is ignored: no queueing, no restart.
- `bin_in` changes after acceptance do not affect the running conversion.
- `bcd_out` and `overflow` change only in the DONE update; they hold otherwise, including through later `start` acceptances.
- Scratch is 10 digits wide so that overflow detection is exact for every 32-bit input (max 4,294,967,295).

## Timing
- Reset (`resetn`=0 at an edge) gives:
  - state IDLE;
  - `busy`=0, `done`=0, `bcd_out`=32'h0, `overflow`=0;
  - counter, scratch and shift register cleared.
- Reset mid-conversion aborts immediately; no `done` pulse follows.
- Reset has priority over `start` at the same edge.
- `start` accepted at edge k:
  - `busy`=1 after edge k;
  - iterations occur at edges k+1..k+32;
  - DONE update occurs at edge k+33. After k+33, `done`=1, `busy`=0 and the new `bcd_out` is visible.
- Start-to-done latency is 33 clocks; `done` is high exactly one cycle.
- A new `start` can be accepted at edge k+34 at the earliest, which gives back-to-back throughput of one conversion per 34 clocks.
- `start` held high continuously restarts a conversion every 34 clocks, each time using the `bin_in` sampled at its own accepting edge.

## Configuration
- `BCD_SATURATE_EN` defined: when overflow is detected at DONE, `bcd_out` ← 32'h99999999 and `overflow`=1.
- `BCD_SATURATE_EN` undefined: `bcd_out` ← low 8 digits (value mod 10^8) and `overflow`=1.
- Values ≤ 99,999,999 behave identically in both builds.

## Test plan
- Reset, then `start` with `bin_in`=32'd0 -> `done` exactly 33 clocks after the accepting edge; `bcd_out`=32'h00000000, `overflow`=0; `busy` high for exactly 33 cycles.
- `bin_in`=32'h00BC614E (12,345,678) -> `bcd_out`=32'h12345678, `overflow`=0. Then `bin_in`=32'h05F5E0FF (99,999,999) -> 32'h99999999, `overflow`=0.
- `bin_in`=32'h05F5E100 (100,000,000) -> `overflow`=1; `bcd_out`=32'h00000000 without the macro, 32'h99999999 with it.
- `bin_in`=32'hFFFFFFFF -> `overflow`=1; `bcd_out`=32'h94967295 without the macro, 32'h99999999 with it.
- Convert 32'd42, then pulse `start` with `bin_in`=32'd7 at clocks 5 and 33 after acceptance, and change `bin_in` mid-run -> both ignored; a single `done` with `bcd_out`=32'h00000042. A `start` at edge k+34 is accepted.
- Convert 32'd1234 to completion, start 32'd5678, then assert `resetn`=0 at iteration 10 -> all outputs 0 on the next cycle and no `done` pulse. A fresh `start` afterwards converts correctly.
